// File: rtl/data_mem_if.sv
// Load/store request and response channel between a core-side requester
// and the data memory responder.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// RV32I data memory with a fixed access latency and a single outstanding
// request; rejects misaligned, out-of-range and illegal-width accesses.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t      state;
  logic [3:0]  counter;
  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] word_sel;
  logic [31:0]      old_word;
  logic [31:0]      store_word;
  logic [31:0]      load_word;
  logic             acc_err;
  logic             access_edge;
  logic             do_write;

  function automatic logic access_error(input logic we, input logic [2:0] funct3,
                                        input logic [31:0] addr);
    logic bad_f3;
    logic misaligned;
    logic out_of_range;
    if (we) begin
      bad_f3 = (funct3 > 3'b010);
    end else begin
      bad_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
    out_of_range = (addr[31:2] >= 30'(DEPTH_WORDS));
    return bad_f3 || misaligned || out_of_range;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  lane);
    logic [31:0] mask;
    logic [31:0] data;
    case (funct3)
      3'b000: begin
        mask = 32'h0000_00FF << {lane, 3'b000};
        data = {24'h00_0000, wdata[7:0]} << {lane, 3'b000};
      end
      3'b001: begin
        mask = 32'h0000_FFFF << {lane[1], 4'b0000};
        data = {16'h0000, wdata[15:0]} << {lane[1], 4'b0000};
      end
      3'b010: begin
        mask = 32'hFFFF_FFFF;
        data = wdata;
      end
      default: begin
        mask = 32'h0000_0000;
        data = 32'h0000_0000;
      end
    endcase
    return (old & ~mask) | (data & mask);
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  lane);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = word >> {lane, 3'b000};
    b       = shifted[7:0];
    h       = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return word;
      3'b100:  return {24'h00_0000, b};
      3'b101:  return {16'h0000, h};
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Decode the latched request and form the write/read data for the access edge.
  always_comb begin
    word_sel    = lat_addr[IDX_W+1:2];
    acc_err     = access_error(lat_we, lat_funct3, lat_addr);
    access_edge = (state == WAIT) && (counter == 4'd1);
    do_write    = access_edge && lat_we && !acc_err;
    if (!acc_err) begin
      old_word = mem[word_sel];
    end else begin
      old_word = 32'h0000_0000;
    end
    store_word = merge_store(old_word, lat_wdata, lat_funct3, lat_addr[1:0]);
    load_word  = extend_load(old_word, lat_funct3, lat_addr[1:0]);
  end

  // Data array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[word_sel] <= store_word;
    end
  end

  // Request/response sequencing with registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      counter       <= 4'd0;
      lat_we        <= 1'b0;
      lat_funct3    <= 3'b000;
      lat_addr      <= 32'h0000_0000;
      lat_wdata     <= 32'h0000_0000;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'h0000_0000;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_we        <= bus.req_we;
            lat_funct3    <= bus.req_funct3;
            lat_addr      <= bus.req_addr;
            lat_wdata     <= bus.req_wdata;
            counter       <= 4'(LATENCY);
            state         <= WAIT;
            bus.req_ready <= 1'b0;
          end
        end
        WAIT: begin
          counter <= counter - 4'd1;
          if (counter == 4'd1) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= acc_err;
            bus.rsp_rdata <= (acc_err || lat_we) ? 32'h0000_0000 : load_word;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          counter       <= 4'd0;
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed checks of the data memory responder: widths, extension, errors,
// backpressure and reset during an outstanding request.
module tb_data_mem_responder;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  data_mem_if dif ();

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction; lat counts edges from accept to rsp_valid.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int lat);
    int n;
    @(negedge clk);
    dif.req_valid  = 1'b1;
    dif.req_we     = we;
    dif.req_funct3 = f3;
    dif.req_addr   = addr;
    dif.req_wdata  = wdata;
    n = 0;
    while (!dif.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    dif.req_valid = 1'b0;
    lat = 0;
    while (!dif.rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rdata = dif.rsp_rdata;
    err   = dif.rsp_err;
    @(negedge clk);
    dif.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    dif.rsp_ready = 1'b0;
  endtask

  task automatic xcheck(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(we, f3, addr, wdata, rd, er, lat);
    check_eq({tag, "_rdata"}, rd, exp_rdata);
    check_eq({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    check_eq({tag, "_lat"}, lat, 32'd2);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    checks         = 0;
    failures       = 0;
    reset          = 1'b0;
    dif.req_valid  = 1'b0;
    dif.req_we     = 1'b0;
    dif.req_funct3 = 3'b000;
    dif.req_addr   = 32'h0000_0000;
    dif.req_wdata  = 32'h0000_0000;
    dif.rsp_ready  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_ready", {31'd0, dif.req_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'd0, dif.rsp_valid}, 32'd0);
    check_eq("rst_rdata", dif.rsp_rdata, 32'h0000_0000);
    check_eq("rst_err", {31'd0, dif.rsp_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // word store/load
    xcheck("sw10", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    xcheck("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // byte store and extension
    xcheck("sw20", 1'b1, 3'b010, 32'h20, 32'h0000_0000, 32'h0, 1'b0);
    xcheck("sb21", 1'b1, 3'b000, 32'h21, 32'h0000_0080, 32'h0, 1'b0);
    xcheck("lb21", 1'b0, 3'b000, 32'h21, 32'h0, 32'hFFFF_FF80, 1'b0);
    xcheck("lbu21", 1'b0, 3'b100, 32'h21, 32'h0, 32'h0000_0080, 1'b0);
    xcheck("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h0000_8000, 1'b0);

    // halfword store into upper half
    xcheck("sw40", 1'b1, 3'b010, 32'h40, 32'h1111_2222, 32'h0, 1'b0);
    xcheck("sh42", 1'b1, 3'b001, 32'h42, 32'h1234_ABCD, 32'h0, 1'b0);
    xcheck("lhu42", 1'b0, 3'b101, 32'h42, 32'h0, 32'h0000_ABCD, 1'b0);
    xcheck("lh42", 1'b0, 3'b001, 32'h42, 32'h0, 32'hFFFF_ABCD, 1'b0);
    xcheck("lw40", 1'b0, 3'b010, 32'h40, 32'h0, 32'hABCD_2222, 1'b0);

    // error cases, memory left untouched
    xcheck("lw13", 1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1);
    xcheck("sw44", 1'b1, 3'b010, 32'h44, 32'h5566_7788, 32'h0, 1'b0);
    xcheck("sh45", 1'b1, 3'b001, 32'h45, 32'hFFFF_FFFF, 32'h0, 1'b1);
    xcheck("lw44", 1'b0, 3'b010, 32'h44, 32'h0, 32'h5566_7788, 1'b0);
    xcheck("lw1000", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);
    xcheck("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    xcheck("st100", 1'b1, 3'b100, 32'h10, 32'h0000_0011, 32'h0, 1'b1);
    xcheck("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    xcheck("swffc", 1'b1, 3'b010, 32'hFFC, 32'hCAFE_F00D, 32'h0, 1'b0);
    xcheck("lwffc", 1'b0, 3'b010, 32'hFFC, 32'h0, 32'hCAFE_F00D, 1'b0);

    // backpressure: response held while further requests are ignored
    @(negedge clk);
    dif.req_valid  = 1'b1;
    dif.req_we     = 1'b0;
    dif.req_funct3 = 3'b010;
    dif.req_addr   = 32'h10;
    @(posedge clk);
    #1;
    dif.req_valid = 1'b0;
    lat = 0;
    while (!dif.rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("bp_lat", lat, 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dif.req_valid  = (i % 2 == 0);
      dif.req_we     = 1'b1;
      dif.req_addr   = 32'h20;
      dif.req_wdata  = 32'h7777_7777;
      @(posedge clk);
      #1;
      check_eq("bp_valid", {31'd0, dif.rsp_valid}, 32'd1);
      check_eq("bp_rdata", dif.rsp_rdata, 32'hDEAD_BEEF);
      check_eq("bp_ready", {31'd0, dif.req_ready}, 32'd0);
    end
    @(negedge clk);
    dif.req_valid = 1'b0;
    dif.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    dif.rsp_ready = 1'b0;
    check_eq("bp_done_valid", {31'd0, dif.rsp_valid}, 32'd0);
    check_eq("bp_done_ready", {31'd0, dif.req_ready}, 32'd1);
    xcheck("lw20_after_bp", 1'b0, 3'b010, 32'h20, 32'h0, 32'h0000_8000, 1'b0);

    // reset during WAIT discards the store
    xcheck("sw80", 1'b1, 3'b010, 32'h80, 32'h0102_0304, 32'h0, 1'b0);
    xcheck("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    dif.req_valid  = 1'b1;
    dif.req_we     = 1'b1;
    dif.req_funct3 = 3'b010;
    dif.req_addr   = 32'h80;
    dif.req_wdata  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    dif.req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("wr_rst_ready", {31'd0, dif.req_ready}, 32'd1);
    check_eq("wr_rst_valid", {31'd0, dif.rsp_valid}, 32'd0);
    check_eq("wr_rst_rdata", dif.rsp_rdata, 32'h0000_0000);
    check_eq("wr_rst_err", {31'd0, dif.rsp_err}, 32'd0);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_eq("wr_rst_norsp", {31'd0, dif.rsp_valid}, 32'd0);
    end
    xcheck("lw80", 1'b0, 3'b010, 32'h80, 32'h0, 32'h0102_0304, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected $finish");
    $fatal(1);
  end

endmodule
